// File: rtl/ldtid_pkg.sv
// Shared types and parameter checks for the CVA6 load TID tracker.
// Optional feature macro used by the tracker: CVA6_LDTID_OCCUPANCY_EN.
`ifndef LDTID_PKG_SV
`define LDTID_PKG_SV

// Per-entry record; widths come from the instantiating module's parameters.
`define LDTID_TYPEDEF_ENTRY(name, trans_w, meta_w) \
  typedef struct packed {                          \
    ldtid_pkg::ld_entry_state_e state;             \
    logic [(trans_w)-1:0]       trans_id;          \
    logic [(meta_w)-1:0]        meta;              \
  } name;

package ldtid_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    KILLED  = 2'd2
  } ld_entry_state_e;

  function automatic bit ldtid_widths_ok(input int unsigned nr_entries,
                                         input int unsigned tid_w);
    return (nr_entries >= 2) && (nr_entries <= 64) &&
           ((nr_entries & (nr_entries - 1)) == 0) &&
           (tid_w >= $clog2(nr_entries));
  endfunction

endpackage

`endif

// File: rtl/cva6_load_tid_tracker_lzc.sv
// Common trailing-zero counter cell: index of the lowest set bit of in_i.
module lzc #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // NOTE: combinational outputs get a default before any conditional write, so no latch is inferred.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/cva6_load_tid_tracker.sv
// Outstanding-load tracker: grants cache TIDs, matches out-of-order responses, drains killed loads.
// Define CVA6_LDTID_OCCUPANCY_EN to add the occupancy_o / high_water_o counters.
module cva6_load_tid_tracker
  import ldtid_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned TID_W      = $clog2(NR_ENTRIES),
  parameter int unsigned TRANS_ID_W = 3,
  parameter int unsigned META_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
  input  logic [META_W-1:0]     alloc_meta_i,
  output logic [TID_W-1:0]      alloc_tid_o,
  input  logic                  kill_valid_i,
  input  logic [TID_W-1:0]      kill_tid_i,
  input  logic                  rsp_valid_i,
  input  logic [TID_W-1:0]      rsp_tid_i,
  output logic                  done_valid_o,
  output logic [TRANS_ID_W-1:0] done_trans_id_o,
  output logic [META_W-1:0]     done_meta_o,
  output logic                  empty_o,
  output logic                  rsp_err_o
`ifdef CVA6_LDTID_OCCUPANCY_EN
  ,
  output logic [$clog2(NR_ENTRIES+1)-1:0] occupancy_o,
  output logic [$clog2(NR_ENTRIES+1)-1:0] high_water_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  if (!ldtid_widths_ok(NR_ENTRIES, TID_W)) begin : g_bad_params
    $error("cva6_load_tid_tracker: NR_ENTRIES must be a power of two in 2..64 and TID_W >= log2");
  end

  `LDTID_TYPEDEF_ENTRY(entry_t, TRANS_ID_W, META_W)

  entry_t                entries_q [NR_ENTRIES];
  entry_t                entries_d [NR_ENTRIES];
  logic                  done_valid_q, done_valid_d;
  logic [TRANS_ID_W-1:0] done_trans_id_q, done_trans_id_d;
  logic [META_W-1:0]     done_meta_q, done_meta_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NR_ENTRIES-1:0] free_vec;
  logic [IDX_W-1:0]      alloc_idx;
  logic                  none_free;
  logic                  alloc_fire;
  logic                  free_evt;

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) free_vec[i] = (entries_q[i].state == FREE);
  end

  lzc #(.WIDTH(NR_ENTRIES)) i_free_pick (
    .in_i    (free_vec),
    .cnt_o   (alloc_idx),
    .empty_o (none_free)
  );

  assign alloc_ready_o = !none_free && !flush_i;
  assign alloc_tid_o   = TID_W'(alloc_idx);
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign empty_o       = &free_vec;

  // TIDs wider than the index space can name entries that do not exist.
  logic             rsp_in_range, kill_in_range;
  logic [IDX_W-1:0] rsp_idx, kill_idx;
  assign rsp_in_range  = 32'(rsp_tid_i) < NR_ENTRIES;
  assign kill_in_range = 32'(kill_tid_i) < NR_ENTRIES;
  assign rsp_idx       = rsp_tid_i[IDX_W-1:0];
  assign kill_idx      = kill_tid_i[IDX_W-1:0];

  always_comb begin
    logic rsp_hit, kill_hit, alloc_hit;
    entries_d       = entries_q;
    done_valid_d    = 1'b0;
    done_trans_id_d = done_trans_id_q;
    done_meta_d     = done_meta_q;
    rsp_err_d       = rsp_valid_i && !rsp_in_range;
    free_evt        = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      rsp_hit   = rsp_valid_i && rsp_in_range && (rsp_idx == IDX_W'(i));
      kill_hit  = flush_i || (kill_valid_i && kill_in_range && (kill_idx == IDX_W'(i)));
      alloc_hit = alloc_fire && (alloc_idx == IDX_W'(i));
      case (entries_q[i].state)
        FREE: begin
          if (rsp_hit) rsp_err_d = 1'b1;
          if (alloc_hit) entries_d[i] = '{state: PENDING, trans_id: alloc_trans_id_i, meta: alloc_meta_i};
        end
        PENDING: begin
          if (rsp_hit) begin
            entries_d[i].state = FREE;
            free_evt           = 1'b1;
            // A kill arriving with the response frees the entry but hides the result.
            if (!kill_hit) begin
              done_valid_d    = 1'b1;
              done_trans_id_d = entries_q[i].trans_id;
              done_meta_d     = entries_q[i].meta;
            end
          end else if (kill_hit) begin
            entries_d[i].state = KILLED;
          end
        end
        KILLED: begin
          if (rsp_hit) begin
            entries_d[i].state = FREE;
            free_evt           = 1'b1;
          end
        end
        default: entries_d[i].state = FREE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the payload fields are reset too,
  // so a stale trans_id can never leak out after a mid-operation reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) entries_q[i] <= '{state: FREE, trans_id: '0, meta: '0};
      done_valid_q    <= 1'b0;
      done_trans_id_q <= '0;
      done_meta_q     <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      entries_q       <= entries_d;
      done_valid_q    <= done_valid_d;
      done_trans_id_q <= done_trans_id_d;
      done_meta_q     <= done_meta_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign done_valid_o    = done_valid_q;
  assign done_trans_id_o = done_trans_id_q;
  assign done_meta_o     = done_meta_q;
  assign rsp_err_o       = rsp_err_q;

`ifdef CVA6_LDTID_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(NR_ENTRIES + 1);

  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic [OCC_W-1:0] high_water_q, high_water_d;

  always_comb begin
    occupancy_d  = occupancy_q + OCC_W'(alloc_fire) - OCC_W'(free_evt);
    high_water_d = (occupancy_d > high_water_q) ? occupancy_d : high_water_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_q  <= '0;
      high_water_q <= '0;
    end else begin
      occupancy_q  <= occupancy_d;
      high_water_q <= high_water_d;
    end
  end

  assign occupancy_o  = occupancy_q;
  assign high_water_o = high_water_q;
`endif

endmodule

// File: tb/tb_cva6_load_tid_tracker.sv
// Self-checking bench for cva6_load_tid_tracker: directed scenarios, random traffic, mid-run reset.
// Honours CVA6_LDTID_OCCUPANCY_EN when the build defines it.
module tb_cva6_load_tid_tracker;

  localparam int NR = 8;

  logic       clk, rst_n;
  logic       flush, alloc_valid, alloc_ready, kill_valid, rsp_valid;
  logic [2:0] alloc_trans_id, alloc_tid, kill_tid, rsp_tid, done_trans_id;
  logic [7:0] alloc_meta, done_meta;
  logic       done_valid, empty, rsp_err;
`ifdef CVA6_LDTID_OCCUPANCY_EN
  logic [3:0] occupancy, high_water;
`endif

  cva6_load_tid_tracker dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .alloc_valid_i    (alloc_valid),
    .alloc_ready_o    (alloc_ready),
    .alloc_trans_id_i (alloc_trans_id),
    .alloc_meta_i     (alloc_meta),
    .alloc_tid_o      (alloc_tid),
    .kill_valid_i     (kill_valid),
    .kill_tid_i       (kill_tid),
    .rsp_valid_i      (rsp_valid),
    .rsp_tid_i        (rsp_tid),
    .done_valid_o     (done_valid),
    .done_trans_id_o  (done_trans_id),
    .done_meta_o      (done_meta),
    .empty_o          (empty),
    .rsp_err_o        (rsp_err)
`ifdef CVA6_LDTID_OCCUPANCY_EN
    ,
    .occupancy_o      (occupancy),
    .high_water_o     (high_water)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which TIDs the cache still owes, and whether each owed load is still wanted.
  bit         busy    [NR];
  bit         live    [NR];
  logic [2:0] m_trans [NR];
  logic [7:0] m_meta  [NR];
  bit         exp_done_v, exp_err;
  logic [2:0] exp_trans;
  logic [7:0] exp_meta;
  int         hw_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      busy[i] = 0;
      live[i] = 0;
    end
    exp_done_v = 0;
    exp_err    = 0;
    exp_trans  = '0;
    exp_meta   = '0;
    hw_model   = 0;
  endtask

  task automatic step(input bit av, input logic [2:0] tr, input logic [7:0] mt,
                      input bit kv, input logic [2:0] kt,
                      input bit rv, input logic [2:0] rt, input bit fl);
    int exp_tid;
    bit exp_ready;
    @(negedge clk);
    alloc_valid = av; alloc_trans_id = tr; alloc_meta = mt;
    kill_valid = kv;  kill_tid = kt;
    rsp_valid = rv;   rsp_tid = rt;
    flush = fl;
    exp_tid = -1;
    for (int i = 0; i < NR; i++) if (!busy[i] && exp_tid < 0) exp_tid = i;
    exp_ready = (exp_tid >= 0) && !fl;
    #1;
    chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    if (exp_ready) chk("alloc_tid", 32'(alloc_tid), 32'(exp_tid));
    chk("empty", 32'(empty), 32'(busy_count() == 0));
    @(posedge clk);
    exp_done_v = 0;
    exp_err    = 0;
    if (rv) begin
      if (!busy[rt]) exp_err = 1;
      else begin
        busy[rt] = 0;
        if (live[rt] && !fl && !(kv && kt == rt)) begin
          exp_done_v = 1;
          exp_trans  = m_trans[rt];
          exp_meta   = m_meta[rt];
        end
      end
    end
    for (int i = 0; i < NR; i++) if (busy[i] && (fl || (kv && int'(kt) == i))) live[i] = 0;
    if (av && exp_ready) begin
      busy[exp_tid]    = 1;
      live[exp_tid]    = 1;
      m_trans[exp_tid] = tr;
      m_meta[exp_tid]  = mt;
    end
    if (busy_count() > hw_model) hw_model = busy_count();
    #1;
    chk("done_valid", 32'(done_valid), 32'(exp_done_v));
    chk("done_trans_id", 32'(done_trans_id), 32'(exp_trans));
    chk("done_meta", 32'(done_meta), 32'(exp_meta));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
`ifdef CVA6_LDTID_OCCUPANCY_EN
    chk("occupancy", 32'(occupancy), 32'(busy_count()));
    chk("high_water", 32'(high_water), 32'(hw_model));
`endif
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic alloc(input logic [2:0] tr, input logic [7:0] mt);
    step(1, tr, mt, 0, '0, 0, '0, 0);
  endtask

  task automatic respond(input logic [2:0] t);
    step(0, '0, '0, 0, '0, 1, t, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) if (busy[i]) respond(3'(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, "_done_trans"}, 32'(done_trans_id), 32'd0);
    chk({tag, "_done_meta"}, 32'(done_meta), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    logic [2:0] rt, kt;
    int         pick;
    rst_n = 1'b0;
    flush = 0; alloc_valid = 0; alloc_trans_id = '0; alloc_meta = '0;
    kill_valid = 0; kill_tid = '0; rsp_valid = 0; rsp_tid = '0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill all eight entries back to back, then confirm the tracker is full.
    for (int i = 0; i < NR; i++) alloc(3'(i) ^ 3'd5, 8'(16 * i + 1));
    idle();
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_empty", 32'(empty), 32'd0);

    // Out-of-order responses, then lowest freed TID is reused.
    respond(3'd5);
    respond(3'd2);
    respond(3'd7);
    chk("reuse_tid", 32'(alloc_tid), 32'd2);
    alloc(3'd1, 8'hA2);
    alloc(3'd2, 8'hA5);
    alloc(3'd3, 8'hA7);

    // Full: response and alloc in the same cycle; the alloc waits one cycle.
    step(1, 3'd4, 8'hB3, 0, '0, 1, 3'd3, 0);
    chk("nobypass_tid", 32'(alloc_tid), 32'd3);
    alloc(3'd4, 8'hB3);
    drain();

    // Flush kills four pending loads; their responses produce no done.
    for (int i = 0; i < 4; i++) alloc(3'(i), 8'(8'hC0 + i));
    step(0, '0, '0, 0, '0, 0, '0, 1);
    drain();
    idle();
    chk("flush_empty", 32'(empty), 32'd1);

    // Alloc presented together with flush is refused.
    step(1, 3'd6, 8'hD0, 0, '0, 0, '0, 1);
    idle();

    // Kill and response on the same TID: entry freed, done suppressed.
    alloc(3'd1, 8'hE0);
    alloc(3'd2, 8'hE1);
    step(0, '0, '0, 1, 3'd1, 1, 3'd1, 0);
    respond(3'd0);
    // Kill to a FREE entry is ignored; then a targeted kill drains without done.
    alloc(3'd3, 8'hE2);
    step(0, '0, '0, 1, 3'd5, 0, '0, 0);
    step(0, '0, '0, 1, 3'd0, 0, '0, 0);
    respond(3'd0);

    // Response to a FREE TID raises rsp_err for one cycle.
    respond(3'd6);
    idle();

`ifdef CVA6_LDTID_OCCUPANCY_EN
    for (int i = 0; i < 5; i++) alloc(3'(i), 8'(8'hF0 + i));
    respond(3'd1);
    respond(3'd3);
    alloc(3'd7, 8'hFF);
    idle();
    chk("occ_value", 32'(occupancy), 32'd4);
    chk("occ_high_water", 32'(high_water), 32'd5);
    drain();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pick = -1;
      for (int i = 0; i < NR; i++) if (busy[i] && (pick < 0 || $urandom_range(0, 1) == 1)) pick = i;
      rt = (pick >= 0 && $urandom_range(0, 4) != 0) ? 3'(pick) : 3'($urandom_range(0, NR - 1));
      kt = 3'($urandom_range(0, NR - 1));
      step($urandom_range(0, 2) != 0, 3'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0, kt,
           $urandom_range(0, 2) != 0, rt,
           $urandom_range(0, 15) == 0);
    end

    // Reset in the middle of traffic drops all state; late responses are errors.
    drain();
    alloc(3'd2, 8'h55);
    alloc(3'd3, 8'h66);
    respond(3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    chk("midreset_ready", 32'(alloc_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    respond(3'd1);
    respond(3'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
